// File: rtl/ibex_fetch_req_ctrl.sv
// ---------------------------------------------------------------------------
// ibex_fetch_req_ctrl
//
// Instruction-fetch request controller. It sits between the core's instruction
// memory port and the push side of the fetch FIFO. It issues word-aligned
// requests, limits the number of in-flight requests to NUM_REQS, throttles on
// the FIFO fill level and redirects on branches. Responses to requests issued
// before a branch are dropped instead of being pushed into the FIFO.
//
// Ports
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   req_i                fetch enable from the IF stage
//   branch_i             single-cycle redirect pulse
//   branch_addr_i        redirect target (half-word aligned)
//   busy_o               request pending or response outstanding
//   instr_req_o          memory request
//   instr_gnt_i          memory grant
//   instr_addr_o         request address, word aligned
//   instr_rvalid_i       response valid, in request order
//   instr_rdata_i        response data
//   instr_err_i          response bus error
//   fifo_clear_o         FIFO clear (on branch)
//   fifo_busy_i          FIFO per-entry occupancy
//   fifo_valid_o         FIFO push strobe
//   fifo_addr_o          FIFO restart address
//   fifo_rdata_o         FIFO push data
//   fifo_err_o           FIFO push error flag
// ---------------------------------------------------------------------------
module ibex_fetch_req_ctrl #(
  parameter int unsigned NUM_REQS = 2
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                req_i,
  input  logic                branch_i,
  input  logic [31:0]         branch_addr_i,
  output logic                busy_o,
  output logic                instr_req_o,
  input  logic                instr_gnt_i,
  output logic [31:0]         instr_addr_o,
  input  logic                instr_rvalid_i,
  input  logic [31:0]         instr_rdata_i,
  input  logic                instr_err_i,
  output logic                fifo_clear_o,
  input  logic [NUM_REQS-1:0] fifo_busy_i,
  output logic                fifo_valid_o,
  output logic [31:0]         fifo_addr_o,
  output logic [31:0]         fifo_rdata_o,
  output logic                fifo_err_o
);

  localparam int unsigned CNT_W = $clog2(NUM_REQS + 1);
  // Outstanding count plus FIFO occupancy can reach 2*NUM_REQS.
  localparam int unsigned SUM_W = $clog2(2 * NUM_REQS + 1);

  logic [29:0]      fetch_addr_q, fetch_addr_d;
  logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
  logic [CNT_W-1:0] disc_cnt_q, disc_cnt_d;
  logic             req_pend_q, req_pend_d;

  logic [SUM_W-1:0] fill;
  logic             room;
  logic             space;
  logic [29:0]      req_word;
  logic             gnt;
  logic             drop;

  // Requests in flight plus entries already held by the FIFO.
  always_comb begin
    fill = SUM_W'(out_cnt_q);
    for (int unsigned i = 0; i < NUM_REQS; i++) begin
      fill = fill + SUM_W'(fifo_busy_i[i]);
    end
  end

  assign room  = out_cnt_q < CNT_W'(NUM_REQS);
  assign space = (fill < SUM_W'(NUM_REQS)) & room;

  // A branch clears the FIFO, so only the in-flight count limits its request.
  // A pending request is held regardless of req_i or the fill level.
  assign instr_req_o  = req_pend_q | (req_i & (space | branch_i) & room);
  assign req_word     = branch_i ? branch_addr_i[31:2] : fetch_addr_q;
  assign instr_addr_o = {req_word, 2'b00};
  assign gnt          = instr_req_o & instr_gnt_i;

  // Drop responses owed to pre-branch requests, and any response that
  // coincides with the branch itself.
  assign drop         = (disc_cnt_q != '0) | branch_i;
  assign fifo_valid_o = instr_rvalid_i & ~drop;
  assign fifo_rdata_o = instr_rdata_i;
  assign fifo_err_o   = instr_err_i;
  assign fifo_clear_o = branch_i;
  assign fifo_addr_o  = branch_addr_i;

  assign busy_o = instr_req_o | (out_cnt_q != '0);

  // NOTE: every signal driven here gets a default first, so no path through
  // the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    fetch_addr_d = req_word;
    out_cnt_d    = out_cnt_q;
    disc_cnt_d   = disc_cnt_q;
    // Granted requests retire the pending flag; a branch re-targets it.
    req_pend_d   = instr_req_o & ~instr_gnt_i;

    if (gnt) begin
      fetch_addr_d = req_word + 30'd1;
    end

    unique case ({gnt, instr_rvalid_i})
      2'b10:   out_cnt_d = out_cnt_q + CNT_W'(1);
      2'b01:   out_cnt_d = out_cnt_q - CNT_W'(1);
      default: out_cnt_d = out_cnt_q;
    endcase

    // A request granted in the branch cycle already carries the target, so
    // only responses still owed from before the branch are discarded.
    if (branch_i) begin
      disc_cnt_d = out_cnt_q - CNT_W'(instr_rvalid_i);
    end else if (instr_rvalid_i && (disc_cnt_q != '0)) begin
      disc_cnt_d = disc_cnt_q - CNT_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fetch_addr_q <= '0;
      out_cnt_q    <= '0;
      disc_cnt_q   <= '0;
      req_pend_q   <= 1'b0;
    end else begin
      fetch_addr_q <= fetch_addr_d;
      out_cnt_q    <= out_cnt_d;
      disc_cnt_q   <= disc_cnt_d;
      req_pend_q   <= req_pend_d;
    end
  end

`ifndef SYNTHESIS
  logic        hold_q;
  logic [31:0] hold_addr_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hold_q      <= 1'b0;
      hold_addr_q <= '0;
    end else begin
      hold_q      <= instr_req_o & ~instr_gnt_i;
      hold_addr_q <= instr_addr_o;
    end
  end

  always @(posedge clk_i) begin
    if (rst_ni) begin
      assert (out_cnt_q <= CNT_W'(NUM_REQS))
        else $error("outstanding count above NUM_REQS");
      assert (!(instr_rvalid_i && (out_cnt_q == '0)))
        else $error("response with nothing outstanding");
      assert (!(hold_q && !branch_i) || (instr_addr_o == hold_addr_q))
        else $error("address changed under a pending request");
      assert (!(fifo_valid_o && fifo_busy_i[NUM_REQS-1]))
        else $error("push into a full FIFO");
    end
  end
`endif

endmodule

// File: tb/tb_ibex_fetch_req_ctrl.sv
// ---------------------------------------------------------------------------
// Directed bench for ibex_fetch_req_ctrl (NUM_REQS = 2). Inputs change 1 time
// unit after the rising edge; outputs are sampled 2 units later, mid-cycle.
// Memory grants and responses are driven by hand each cycle.
// ---------------------------------------------------------------------------
module tb_ibex_fetch_req_ctrl;

  localparam int unsigned NUM_REQS = 2;

  logic                clk_i = 1'b0;
  logic                rst_ni;
  logic                req_i;
  logic                branch_i;
  logic [31:0]         branch_addr_i;
  logic                busy_o;
  logic                instr_req_o;
  logic                instr_gnt_i;
  logic [31:0]         instr_addr_o;
  logic                instr_rvalid_i;
  logic [31:0]         instr_rdata_i;
  logic                instr_err_i;
  logic                fifo_clear_o;
  logic [NUM_REQS-1:0] fifo_busy_i;
  logic                fifo_valid_o;
  logic [31:0]         fifo_addr_o;
  logic [31:0]         fifo_rdata_o;
  logic                fifo_err_o;

  int n_checks = 0;
  int n_fail   = 0;

  ibex_fetch_req_ctrl #(.NUM_REQS(NUM_REQS)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .req_i          (req_i),
    .branch_i       (branch_i),
    .branch_addr_i  (branch_addr_i),
    .busy_o         (busy_o),
    .instr_req_o    (instr_req_o),
    .instr_gnt_i    (instr_gnt_i),
    .instr_addr_o   (instr_addr_o),
    .instr_rvalid_i (instr_rvalid_i),
    .instr_rdata_i  (instr_rdata_i),
    .instr_err_i    (instr_err_i),
    .fifo_clear_o   (fifo_clear_o),
    .fifo_busy_i    (fifo_busy_i),
    .fifo_valid_o   (fifo_valid_o),
    .fifo_addr_o    (fifo_addr_o),
    .fifo_rdata_o   (fifo_rdata_o),
    .fifo_err_o     (fifo_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one cycle, drive this cycle's inputs, settle to mid-cycle.
  task automatic cyc(input logic req, input logic br, input logic [31:0] baddr,
                     input logic gnt, input logic rv, input logic [31:0] rdata,
                     input logic err, input logic [NUM_REQS-1:0] busy);
    @(posedge clk_i);
    #1;
    req_i          = req;
    branch_i       = br;
    branch_addr_i  = baddr;
    instr_gnt_i    = gnt;
    instr_rvalid_i = rv;
    instr_rdata_i  = rdata;
    instr_err_i    = err;
    fifo_busy_i    = busy;
    #2;
  endtask

  initial begin
    rst_ni         = 1'b0;
    req_i          = 1'b0;
    branch_i       = 1'b0;
    branch_addr_i  = '0;
    instr_gnt_i    = 1'b0;
    instr_rvalid_i = 1'b0;
    instr_rdata_i  = '0;
    instr_err_i    = 1'b0;
    fifo_busy_i    = '0;

    // Reset state
    #12;
    check1("rst_req",   instr_req_o,  1'b0);
    check1("rst_valid", fifo_valid_o, 1'b0);
    check1("rst_clear", fifo_clear_o, 1'b0);
    check1("rst_busy",  busy_o,       1'b0);
    #1 rst_ni = 1'b1;

    // Branch to 0x100 with single-cycle grant/response memory
    cyc(1, 1, 32'h100, 1, 0, 32'h0, 0, 2'b00);
    check1 ("a_req",       instr_req_o,  1'b1);
    check32("a_addr",      instr_addr_o, 32'h100);
    check1 ("a_clear",     fifo_clear_o, 1'b1);
    check32("a_fifo_addr", fifo_addr_o,  32'h100);
    check1 ("a_valid",     fifo_valid_o, 1'b0);

    cyc(1, 0, 32'h0, 1, 1, 32'hAAAA0100, 0, 2'b00);
    check32("b_addr",  instr_addr_o, 32'h104);
    check1 ("b_valid", fifo_valid_o, 1'b1);
    check32("b_rdata", fifo_rdata_o, 32'hAAAA0100);
    check1 ("b_clear", fifo_clear_o, 1'b0);

    cyc(1, 0, 32'h0, 1, 1, 32'hAAAA0104, 0, 2'b00);
    check32("c_addr",  instr_addr_o, 32'h108);
    check1 ("c_valid", fifo_valid_o, 1'b1);

    // req_i low: last response still retires into the FIFO
    cyc(0, 0, 32'h0, 0, 1, 32'hAAAA0108, 0, 2'b00);
    check1 ("d_req",   instr_req_o,  1'b0);
    check1 ("d_valid", fifo_valid_o, 1'b1);
    check32("d_rdata", fifo_rdata_o, 32'hAAAA0108);
    check1 ("d_busy",  busy_o,       1'b1);

    cyc(0, 0, 32'h0, 0, 0, 32'h0, 0, 2'b00);
    check1("e_busy", busy_o, 1'b0);

    // Grant withheld three cycles at 0x200 (req_i dropped mid-wait)
    cyc(1, 1, 32'h200, 0, 0, 32'h0, 0, 2'b00);
    check1 ("f_req",  instr_req_o,  1'b1);
    check32("f_addr", instr_addr_o, 32'h200);
    cyc(0, 0, 32'h0, 0, 0, 32'h0, 0, 2'b00);
    check1 ("g_req",  instr_req_o,  1'b1);
    check32("g_addr", instr_addr_o, 32'h200);
    cyc(1, 0, 32'h0, 0, 0, 32'h0, 0, 2'b00);
    check1 ("h_req",  instr_req_o,  1'b1);
    check32("h_addr", instr_addr_o, 32'h200);
    cyc(1, 0, 32'h0, 1, 0, 32'h0, 0, 2'b00);
    check32("i_addr", instr_addr_o, 32'h200);
    cyc(1, 0, 32'h0, 1, 0, 32'h0, 0, 2'b00);
    check1 ("j_req",  instr_req_o,  1'b1);
    check32("j_addr", instr_addr_o, 32'h204);

    // Two outstanding, then branch to 0x40A
    cyc(1, 1, 32'h40A, 0, 0, 32'h0, 0, 2'b00);
    check32("k_addr",      instr_addr_o, 32'h408);
    check1 ("k_req_full",  instr_req_o,  1'b0);
    check1 ("k_clear",     fifo_clear_o, 1'b1);
    check32("k_fifo_addr", fifo_addr_o,  32'h40A);
    cyc(1, 0, 32'h0, 0, 1, 32'h11110200, 0, 2'b00);
    check32("l_disc",  32'(dut.disc_cnt_q), 32'd2);
    check1 ("l_valid", fifo_valid_o, 1'b0);
    cyc(1, 0, 32'h0, 1, 1, 32'h11110204, 0, 2'b00);
    check1 ("m_valid", fifo_valid_o, 1'b0);
    check1 ("m_req",   instr_req_o,  1'b1);
    check32("m_addr",  instr_addr_o, 32'h408);
    cyc(0, 0, 32'h0, 0, 1, 32'hDEAD0408, 0, 2'b00);
    check1 ("n_valid", fifo_valid_o, 1'b1);
    check32("n_rdata", fifo_rdata_o, 32'hDEAD0408);

    // Response coincident with a branch
    cyc(1, 0, 32'h0, 1, 0, 32'h0, 0, 2'b00);
    check32("o_addr", instr_addr_o, 32'h40C);
    cyc(1, 0, 32'h0, 1, 0, 32'h0, 0, 2'b00);
    check32("p_addr", instr_addr_o, 32'h410);
    cyc(1, 1, 32'h500, 0, 1, 32'h2222040C, 0, 2'b00);
    check1("q_valid", fifo_valid_o, 1'b0);
    check1("q_req",   instr_req_o,  1'b0);
    cyc(0, 0, 32'h0, 0, 1, 32'h22220410, 0, 2'b00);
    check32("r_disc",  32'(dut.disc_cnt_q), 32'd1);
    check32("r_out",   32'(dut.out_cnt_q),  32'd1);
    check1 ("r_valid", fifo_valid_o, 1'b0);

    // FIFO fill-level throttling
    cyc(1, 0, 32'h0, 0, 0, 32'h0, 0, 2'b11);
    check1("s_req",  instr_req_o, 1'b0);
    check1("s_busy", busy_o,      1'b0);
    cyc(1, 0, 32'h0, 1, 0, 32'h0, 0, 2'b01);
    check1 ("t_req",  instr_req_o,  1'b1);
    check32("t_addr", instr_addr_o, 32'h500);
    cyc(1, 0, 32'h0, 0, 0, 32'h0, 0, 2'b01);
    check1("u_req",  instr_req_o, 1'b0);
    check1("u_busy", busy_o,      1'b1);
    cyc(1, 0, 32'h0, 1, 1, 32'h33330500, 0, 2'b00);
    check1 ("v_req",   instr_req_o,  1'b1);
    check32("v_addr",  instr_addr_o, 32'h504);
    check1 ("v_valid", fifo_valid_o, 1'b1);
    cyc(0, 0, 32'h0, 0, 1, 32'h33330504, 0, 2'b00);
    check1("w_valid", fifo_valid_o, 1'b1);
    check1("w_req",   instr_req_o,  1'b0);

    // Bus error forwarded as data, fetching continues
    cyc(1, 1, 32'h300, 1, 0, 32'h0, 0, 2'b00);
    check32("x_addr", instr_addr_o, 32'h300);
    cyc(1, 0, 32'h0, 1, 1, 32'hBAD00300, 1, 2'b00);
    check1 ("y_valid", fifo_valid_o, 1'b1);
    check1 ("y_err",   fifo_err_o,   1'b1);
    check32("y_addr",  instr_addr_o, 32'h304);
    cyc(0, 0, 32'h0, 0, 1, 32'h0ACE0304, 0, 2'b00);
    check1("z_valid", fifo_valid_o, 1'b1);
    check1("z_err",   fifo_err_o,   1'b0);

    // Asynchronous reset with a request outstanding
    cyc(1, 0, 32'h0, 1, 0, 32'h0, 0, 2'b00);
    check32("aa_addr", instr_addr_o, 32'h308);
    cyc(0, 0, 32'h0, 0, 0, 32'h0, 0, 2'b00);
    check1("bb_busy", busy_o, 1'b1);
    #1 rst_ni = 1'b0;
    #1;
    check1 ("ar_busy", busy_o,              1'b0);
    check32("ar_out",  32'(dut.out_cnt_q),  32'd0);
    check32("ar_addr", instr_addr_o,        32'h0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (2) @(posedge clk_i);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
